// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the MIPS hazard/forwarding unit: forwarding selects,
// the shadow stage record, and the forwarding-select helper.
package pipe_hazard_unit_pkg;

    localparam int SHADOW_REG_W = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef struct packed {
        logic [SHADOW_REG_W-1:0] rs;
        logic [SHADOW_REG_W-1:0] rt;
        logic [SHADOW_REG_W-1:0] dst;
        logic                    regwrite;
        logic                    memread;
    } stage_t;

    // $0 is hardwired, so a write to it never produces a value worth forwarding
    function automatic logic [1:0] fwd_sel(input stage_t mem, input stage_t wb,
                                           input logic [SHADOW_REG_W-1:0] src);
        if (mem.regwrite && mem.dst != '0 && mem.dst == src) return FWD_MEM;
        if (wb.regwrite && wb.dst != '0 && wb.dst == src) return FWD_WB;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_stage_reg.sv
// One shadow pipeline stage: async active-low reset plus a synchronous clear
// used to squash the record when the datapath inserts a bubble or flush.
module hazard_stage_reg
    import pipe_hazard_unit_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  stage_t d,
    output stage_t q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     q <= '0;
        else if (clr) q <= '0;
        else          q <= d;
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and EX forwarding for the 5-stage MIPS pipeline, driven
// from a private shadow copy of the EX/MEM/WB destination information.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_jmp,
    input  logic             id_jr,
    input  logic             branch_taken,
    output logic             Bubble,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IF_Flush,
    output logic             EX_Flush,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_t id_rec, ex, mem, wb;
    logic   load_stall, jr_stall, stall;
    logic   unused;

    assign id_rec = '{rs: id_rs, rt: id_rt, dst: id_dst,
                      regwrite: id_regwrite, memread: id_memread};

    hazard_stage_reg u_ex  (.clk(clk), .rst(rst), .clr(!Bubble),  .d(id_rec), .q(ex));
    hazard_stage_reg u_mem (.clk(clk), .rst(rst), .clr(EX_Flush), .d(ex),     .q(mem));
    hazard_stage_reg u_wb  (.clk(clk), .rst(rst), .clr(1'b0),     .d(mem),    .q(wb));

    assign unused = ^{wb.rs, wb.rt, wb.memread};

    always_comb begin
        load_stall = ex.memread && ex.dst != '0 &&
                     ((id_uses_rs && ex.dst == id_rs) || (id_uses_rt && ex.dst == id_rt));
        // No ID-stage forwarding: jr waits until its producer reaches WB
        jr_stall   = id_jr && id_rs != '0 &&
                     ((ex.regwrite && ex.dst == id_rs) || (mem.regwrite && mem.dst == id_rs));
        stall      = (load_stall || jr_stall) && !branch_taken;

        Bubble    = 1'b1;
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IF_Flush  = 1'b0;
        EX_Flush  = 1'b0;
        if (rst) begin
            if (branch_taken) begin
                // the stalled ID instruction is wrong-path, so the stall is dropped
                Bubble   = 1'b0;
                IF_Flush = 1'b1;
                EX_Flush = 1'b1;
            end else if (stall) begin
                Bubble    = 1'b0;
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IF_Flush  = id_jmp && !jr_stall;
            end else begin
                IF_Flush = id_jmp;
            end
        end
    end

    assign ForwardA = fwd_sel(mem, wb, ex.rs);
    assign ForwardB = fwd_sel(mem, wb, ex.rt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (!PCWrite && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed test of pipe_hazard_unit: stalls, forwarding, jumps, branches,
// $0 handling, asynchronous reset and counter saturation.
module tb_pipe_hazard_unit;

    localparam int REG_W = 5;
    localparam int CW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [REG_W-1:0] id_rs, id_rt, id_dst;
    logic id_uses_rs, id_uses_rt, id_regwrite, id_memread, id_jmp, id_jr, branch_taken;
    logic Bubble, PCWrite, IFIDWrite, IF_Flush, EX_Flush;
    logic [1:0] ForwardA, ForwardB;
    logic [CW-1:0] stall_cnt;
    logic [4:0] ctrl;
    logic [3:0] fwd;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    // {Bubble, PCWrite, IFIDWrite, IF_Flush, EX_Flush}
    assign ctrl = {Bubble, PCWrite, IFIDWrite, IF_Flush, EX_Flush};
    assign fwd  = {ForwardA, ForwardB};

    pipe_hazard_unit #(.REG_W(REG_W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_jmp(id_jmp), .id_jr(id_jr), .branch_taken(branch_taken),
        .Bubble(Bubble), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IF_Flush(IF_Flush), .EX_Flush(EX_Flush),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .stall_cnt(stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int rs, input int rt, input int urs, input int urt,
                          input int dst, input int rw, input int mr, input int jmp, input int jr);
        id_rs       = REG_W'(rs);
        id_rt       = REG_W'(rt);
        id_uses_rs  = (urs != 0);
        id_uses_rt  = (urt != 0);
        id_dst      = REG_W'(dst);
        id_regwrite = (rw != 0);
        id_memread  = (mr != 0);
        id_jmp      = (jmp != 0);
        id_jr       = (jr != 0);
        #2;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            nop();
        end
    endtask

    task automatic test_reset();
        branch_taken = 1'b0;
        nop();
        total++; if (ctrl !== 5'b11100) begin bad++; $display("FAIL rst_ctrl got=%b exp=%b", ctrl, 5'b11100); end
        total++; if (fwd !== 4'b0000) begin bad++; $display("FAIL rst_fwd got=%b exp=%b", fwd, 4'b0000); end
        total++; if (stall_cnt !== CW'(0)) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
        step();
        rst = 1'b1;
    endtask

    task automatic test_load_use();
        step(); set_id(1, 5, 1, 0, 5, 1, 1, 0, 0);   // lw $5
        total++; if (ctrl !== 5'b11100) begin bad++; $display("FAIL lu_pre got=%b exp=%b", ctrl, 5'b11100); end
        step(); set_id(5, 7, 1, 1, 6, 1, 0, 0, 0);   // add $6,$5,$7
        total++; if (ctrl !== 5'b00000) begin bad++; $display("FAIL lu_stall got=%b exp=%b", ctrl, 5'b00000); end
        step(); #2;
        exp_cnt++;
        total++; if (ctrl !== 5'b11100) begin bad++; $display("FAIL lu_release got=%b exp=%b", ctrl, 5'b11100); end
        total++; if (stall_cnt !== CW'(exp_cnt)) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        step(); nop();
        total++; if (fwd !== 4'b0100) begin bad++; $display("FAIL lu_fwd got=%b exp=%b", fwd, 4'b0100); end
    endtask

    task automatic test_forwarding();
        drain(3);
        step(); set_id(1, 2, 1, 1, 3, 1, 0, 0, 0);   // add $3,$1,$2
        step(); set_id(3, 8, 1, 1, 4, 1, 0, 0, 0);   // sub $4,$3,$8
        step(); set_id(9, 3, 1, 1, 5, 1, 0, 0, 0);   // or  $5,$9,$3
        total++; if (fwd !== 4'b1000) begin bad++; $display("FAIL fw_sub got=%b exp=%b", fwd, 4'b1000); end
        total++; if (ctrl !== 5'b11100) begin bad++; $display("FAIL fw_nostall got=%b exp=%b", ctrl, 5'b11100); end
        step(); nop();
        total++; if (fwd !== 4'b0001) begin bad++; $display("FAIL fw_or got=%b exp=%b", fwd, 4'b0001); end
        step(); set_id(1, 2, 1, 1, 3, 1, 0, 0, 0);   // add $3
        step(); set_id(4, 5, 1, 1, 3, 1, 0, 0, 0);   // add $3 again
        step(); set_id(3, 3, 1, 1, 6, 1, 0, 0, 0);   // add $6,$3,$3
        step(); nop();
        total++; if (fwd !== 4'b1010) begin bad++; $display("FAIL fw_prio got=%b exp=%b", fwd, 4'b1010); end
    endtask

    task automatic test_jr();
        drain(3);
        step(); set_id(29, 31, 1, 0, 31, 1, 1, 0, 0); // lw $31
        step(); set_id(31, 0, 1, 0, 0, 0, 0, 1, 1);   // jr $31
        total++; if (ctrl !== 5'b00000) begin bad++; $display("FAIL jr_stall1 got=%b exp=%b", ctrl, 5'b00000); end
        step(); #2;
        total++; if (ctrl !== 5'b00000) begin bad++; $display("FAIL jr_stall2 got=%b exp=%b", ctrl, 5'b00000); end
        step(); #2;
        exp_cnt += 2;
        total++; if (ctrl !== 5'b11110) begin bad++; $display("FAIL jr_go got=%b exp=%b", ctrl, 5'b11110); end
        total++; if (stall_cnt !== CW'(exp_cnt)) begin bad++; $display("FAIL jr_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        step(); nop();
        total++; if (ctrl !== 5'b11100) begin bad++; $display("FAIL jr_flush_once got=%b exp=%b", ctrl, 5'b11100); end
        step(); set_id(1, 2, 1, 1, 7, 1, 0, 0, 0);    // add $7
        step(); nop();
        step(); set_id(7, 0, 1, 0, 0, 0, 0, 1, 1);    // jr $7, producer in MEM
        total++; if (ctrl !== 5'b00000) begin bad++; $display("FAIL jr_mem_stall got=%b exp=%b", ctrl, 5'b00000); end
        step(); #2;
        exp_cnt++;
        total++; if (ctrl !== 5'b11110) begin bad++; $display("FAIL jr_mem_go got=%b exp=%b", ctrl, 5'b11110); end
        total++; if (stall_cnt !== CW'(exp_cnt)) begin bad++; $display("FAIL jr_mem_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        step(); nop();
    endtask

    task automatic test_branch();
        drain(3);
        step(); set_id(1, 5, 1, 0, 5, 1, 1, 0, 0);    // lw $5
        step(); branch_taken = 1'b1; set_id(5, 7, 1, 1, 6, 1, 0, 0, 0);
        total++; if (ctrl !== 5'b01111) begin bad++; $display("FAIL br_cancel got=%b exp=%b", ctrl, 5'b01111); end
        // jr $5 would stall if the lw had survived into MEM
        step(); branch_taken = 1'b0; set_id(5, 0, 1, 0, 0, 0, 0, 1, 1);
        total++; if (ctrl !== 5'b11110) begin bad++; $display("FAIL br_mem_clear got=%b exp=%b", ctrl, 5'b11110); end
        total++; if (stall_cnt !== CW'(exp_cnt)) begin bad++; $display("FAIL br_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        step(); nop();
    endtask

    task automatic test_zero();
        drain(3);
        step(); set_id(1, 2, 1, 1, 0, 1, 0, 0, 0);    // add $0
        step(); set_id(0, 0, 1, 0, 0, 1, 1, 0, 0);    // lw $0,0($0)
        step(); set_id(0, 0, 1, 1, 3, 1, 0, 0, 0);    // add $3,$0,$0
        total++; if (ctrl !== 5'b11100) begin bad++; $display("FAIL z_load got=%b exp=%b", ctrl, 5'b11100); end
        total++; if (fwd !== 4'b0000) begin bad++; $display("FAIL z_fwd1 got=%b exp=%b", fwd, 4'b0000); end
        step(); set_id(0, 0, 1, 0, 0, 0, 0, 1, 1);    // jr $0
        total++; if (ctrl !== 5'b11110) begin bad++; $display("FAIL z_jr got=%b exp=%b", ctrl, 5'b11110); end
        total++; if (fwd !== 4'b0000) begin bad++; $display("FAIL z_fwd2 got=%b exp=%b", fwd, 4'b0000); end
        step(); nop();
    endtask

    task automatic test_reset_mid_stall();
        drain(3);
        step(); set_id(1, 5, 1, 0, 5, 1, 1, 0, 0);
        step(); set_id(5, 7, 1, 1, 6, 1, 0, 0, 0);
        total++; if (ctrl !== 5'b00000) begin bad++; $display("FAIL rm_stall got=%b exp=%b", ctrl, 5'b00000); end
        rst = 1'b0;
        #1;
        total++; if (ctrl !== 5'b11100) begin bad++; $display("FAIL rm_ctrl got=%b exp=%b", ctrl, 5'b11100); end
        total++; if (fwd !== 4'b0000) begin bad++; $display("FAIL rm_fwd got=%b exp=%b", fwd, 4'b0000); end
        total++; if (stall_cnt !== CW'(0)) begin bad++; $display("FAIL rm_cnt got=%0d exp=0", stall_cnt); end
        nop();
        step();
        rst = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            step(); set_id(1, 5, 1, 0, 5, 1, 1, 0, 0);
            if (i == (1 << CW) - 2) begin
                total++; if (stall_cnt !== CW'(i)) begin bad++; $display("FAIL sat_count got=%0d exp=%0d", stall_cnt, i); end
            end
            if (i == (1 << CW) + 1) begin
                total++; if (stall_cnt !== {CW{1'b1}}) begin bad++; $display("FAIL sat_hold got=%0d exp=%0d", stall_cnt, (1 << CW) - 1); end
            end
            step(); set_id(5, 7, 1, 1, 6, 1, 0, 0, 0);
        end
        step(); nop();
        total++; if (stall_cnt !== {CW{1'b1}}) begin bad++; $display("FAIL sat_final got=%0d exp=%0d", stall_cnt, (1 << CW) - 1); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_jr();
        test_branch();
        test_zero();
        test_reset_mid_stall();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
